// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad code-lock controller.
package lock_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_OPEN     = 3'd2,
    ST_NEW_CODE = 3'd3,
    ST_ERROR    = 3'd4,
    ST_LOCKOUT  = 3'd5
  } state_t;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hB;
  localparam logic [3:0] KEY_SET   = 4'hC;

  localparam logic [15:0] DISP_BLANK = 16'hFFFF;
  localparam logic [15:0] DISP_OPEN  = 16'hAAAA;
  localparam logic [15:0] DISP_ERR   = 16'hEEEE;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic int unsigned max5(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d,
                                       input int unsigned e);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/lock_if.sv
// Key-event input and display/actuator output bundle of the code lock.
interface lock_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] disp_data;
  logic        disp_en;
  logic        unlock;
  logic        alarm;

  modport master (output key_valid, key_code, input disp_data, disp_en, unlock, alarm);
  modport slave  (input key_valid, key_code, output disp_data, disp_en, unlock, alarm);
endinterface

// File: rtl/lock_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module lock_timer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  localparam logic [W-1:0] ONE = W'(32'd1);

  logic [W-1:0] count_r;

  // Count register: load wins, otherwise decrement until zero and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= value;
    end else if (count_r != {W{1'b0}}) begin
      count_r <= count_r - ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == {W{1'b0}});

endmodule

// File: rtl/lock_ctrl.sv
// Keypad code-lock controller: entry/compare/lockout FSM, stored code and
// registered display/actuator outputs. Timers load N-1 so each dwell is N cycles.
module lock_ctrl
  import lock_pkg::*;
#(
  parameter logic [15:0] DEFAULT_CODE = 16'h1234,
  parameter int unsigned MAX_TRIES    = 32'd3,
  parameter int unsigned OPEN_CYCLES  = 32'd250_000_000,
  parameter int unsigned ERR_CYCLES   = 32'd50_000_000,
  parameter int unsigned LOCK_CYCLES  = 32'd1_500_000_000,
  parameter int unsigned IDLE_TIMEOUT = 32'd500_000_000,
  parameter int unsigned BLINK_CYCLES = 32'd12_500_000
) (
  input  logic clk,
  input  logic rst,
  lock_if.slave bus
);

  localparam int unsigned MAX_CYC = max5(OPEN_CYCLES, ERR_CYCLES, LOCK_CYCLES,
                                         IDLE_TIMEOUT, BLINK_CYCLES);
  localparam int TW = $clog2(MAX_CYC) + 1;
  localparam int BW = $clog2(BLINK_CYCLES) + 1;
  localparam int FW = $clog2(MAX_TRIES + 32'd1);

  localparam logic [TW-1:0] OPEN_LOAD  = TW'(OPEN_CYCLES - 32'd1);
  localparam logic [TW-1:0] ERR_LOAD   = TW'(ERR_CYCLES - 32'd1);
  localparam logic [TW-1:0] LOCK_LOAD  = TW'(LOCK_CYCLES - 32'd1);
  localparam logic [TW-1:0] IDLE_LOAD  = TW'(IDLE_TIMEOUT - 32'd1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_CYCLES - 32'd1);
  localparam logic [BW-1:0] BLINK_ONE  = BW'(32'd1);
  localparam logic [FW-1:0] MAX_FAIL   = FW'(MAX_TRIES);
  localparam logic [FW-1:0] ONE_FAIL   = FW'(32'd1);

  state_t        state_r, state_s;
  logic [15:0]   code_r, code_s;
  logic [15:0]   buf_r, buf_s, buf_shift_s;
  logic [2:0]    cnt_r, cnt_s;
  logic [FW-1:0] fail_r, fail_s, fail_inc_s;
  logic [BW-1:0] blink_cnt_r, blink_cnt_s;
  logic          blink_r, blink_s;
  logic          tmr_load_s, tmr_expired_s;
  logic [TW-1:0] tmr_value_s;
  logic [15:0]   disp_data_r, disp_data_s;
  logic          disp_en_r, disp_en_s, unlock_r, unlock_s, alarm_r, alarm_s;
  logic          key_s, digit_s, entry_full_s;

  assign key_s        = bus.key_valid;
  assign digit_s      = bus.key_valid & is_digit(bus.key_code);
  assign entry_full_s = (cnt_r == 3'd4);
  assign buf_shift_s  = {buf_r[11:0], bus.key_code};
  assign fail_inc_s   = (fail_r >= MAX_FAIL) ? MAX_FAIL : (fail_r + ONE_FAIL);

  lock_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load_s),
    .value   (tmr_value_s),
    .expired (tmr_expired_s)
  );

  // Next-state, code/buffer/fail-count updates and timer reloads; expiry beats any key.
  always_comb begin
    state_s     = state_r;
    code_s      = code_r;
    buf_s       = buf_r;
    cnt_s       = cnt_r;
    fail_s      = fail_r;
    tmr_load_s  = 1'b0;
    tmr_value_s = IDLE_LOAD;
    case (state_r)
      ST_IDLE: begin
        if (digit_s) begin
          state_s    = ST_ENTRY;
          buf_s      = {12'hFFF, bus.key_code};
          cnt_s      = 3'd1;
          tmr_load_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ENTRY, ST_NEW_CODE: begin
        if (tmr_expired_s) begin
          state_s = ST_IDLE;
          buf_s   = DISP_BLANK;
          cnt_s   = 3'd0;
        end else if (key_s) begin
          tmr_load_s = 1'b1;
          if (digit_s) begin
            if (!entry_full_s) begin
              buf_s = buf_shift_s;
              cnt_s = cnt_r + 3'd1;
            end else begin
              buf_s = buf_r;
            end
          end else if (bus.key_code == KEY_CLEAR) begin
            if (state_r == ST_ENTRY) begin
              state_s = ST_IDLE;
              buf_s   = DISP_BLANK;
              cnt_s   = 3'd0;
            end else begin
              state_s     = ST_OPEN;
              tmr_value_s = OPEN_LOAD;
            end
          end else if (bus.key_code == KEY_ENTER) begin
            if (state_r == ST_NEW_CODE) begin
              if (entry_full_s) begin
                code_s      = buf_r;
                state_s     = ST_OPEN;
                tmr_value_s = OPEN_LOAD;
              end else begin
                state_s = ST_NEW_CODE;
              end
            end else if (entry_full_s && (buf_r == code_r)) begin
              state_s     = ST_OPEN;
              fail_s      = {FW{1'b0}};
              tmr_value_s = OPEN_LOAD;
            end else if (fail_inc_s == MAX_FAIL) begin
              state_s     = ST_LOCKOUT;
              fail_s      = fail_inc_s;
              tmr_value_s = LOCK_LOAD;
            end else begin
              state_s     = ST_ERROR;
              fail_s      = fail_inc_s;
              tmr_value_s = ERR_LOAD;
            end
          end else begin
            state_s = state_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      ST_OPEN: begin
        if (tmr_expired_s || (key_s && (bus.key_code == KEY_CLEAR))) begin
          state_s = ST_IDLE;
          buf_s   = DISP_BLANK;
          cnt_s   = 3'd0;
        end else if (key_s && (bus.key_code == KEY_SET)) begin
          state_s    = ST_NEW_CODE;
          buf_s      = DISP_BLANK;
          cnt_s      = 3'd0;
          tmr_load_s = 1'b1;
        end else begin
          state_s = ST_OPEN;
        end
      end
      ST_ERROR, ST_LOCKOUT: begin
        if (tmr_expired_s) begin
          state_s = ST_IDLE;
          buf_s   = DISP_BLANK;
          cnt_s   = 3'd0;
          if (state_r == ST_LOCKOUT) begin
            fail_s = {FW{1'b0}};
          end else begin
            fail_s = fail_r;
          end
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        buf_s   = DISP_BLANK;
        cnt_s   = 3'd0;
      end
    endcase
  end

  // Lockout blink: starts lit on entry and toggles every BLINK_CYCLES.
  always_comb begin
    blink_cnt_s = {BW{1'b0}};
    blink_s     = 1'b0;
    if ((state_s == ST_LOCKOUT) && (state_r != ST_LOCKOUT)) begin
      blink_cnt_s = BLINK_LOAD;
      blink_s     = 1'b1;
    end else if (state_s == ST_LOCKOUT) begin
      if (blink_cnt_r == {BW{1'b0}}) begin
        blink_cnt_s = BLINK_LOAD;
        blink_s     = ~blink_r;
      end else begin
        blink_cnt_s = blink_cnt_r - BLINK_ONE;
        blink_s     = blink_r;
      end
    end else begin
      blink_cnt_s = {BW{1'b0}};
      blink_s     = 1'b0;
    end
  end

  // Output decode from the next state so outputs change on the same edge as the state.
  always_comb begin
    disp_data_s = DISP_BLANK;
    disp_en_s   = 1'b0;
    unlock_s    = 1'b0;
    alarm_s     = 1'b0;
    case (state_s)
      ST_IDLE: begin
        disp_data_s = DISP_BLANK;
      end
      ST_ENTRY: begin
        disp_data_s = buf_s;
        disp_en_s   = 1'b1;
      end
      ST_OPEN: begin
        disp_data_s = DISP_OPEN;
        disp_en_s   = 1'b1;
        unlock_s    = 1'b1;
      end
      ST_NEW_CODE: begin
        disp_data_s = buf_s;
        disp_en_s   = 1'b1;
        unlock_s    = 1'b1;
      end
      ST_ERROR: begin
        disp_data_s = DISP_ERR;
        disp_en_s   = 1'b1;
      end
      ST_LOCKOUT: begin
        disp_data_s = DISP_ERR;
        disp_en_s   = blink_s;
        alarm_s     = 1'b1;
      end
      default: begin
        disp_data_s = DISP_BLANK;
      end
    endcase
  end

  // State, code, entry buffer and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      code_r      <= DEFAULT_CODE;
      buf_r       <= DISP_BLANK;
      cnt_r       <= 3'd0;
      fail_r      <= {FW{1'b0}};
      blink_cnt_r <= {BW{1'b0}};
      blink_r     <= 1'b0;
      disp_data_r <= DISP_BLANK;
      disp_en_r   <= 1'b0;
      unlock_r    <= 1'b0;
      alarm_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      code_r      <= code_s;
      buf_r       <= buf_s;
      cnt_r       <= cnt_s;
      fail_r      <= fail_s;
      blink_cnt_r <= blink_cnt_s;
      blink_r     <= blink_s;
      disp_data_r <= disp_data_s;
      disp_en_r   <= disp_en_s;
      unlock_r    <= unlock_s;
      alarm_r     <= alarm_s;
    end
  end

  assign bus.disp_data = disp_data_r;
  assign bus.disp_en   = disp_en_r;
  assign bus.unlock    = unlock_r;
  assign bus.alarm     = alarm_r;

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl: a mode-level model checked every cycle plus literal spot checks.
module tb_lock_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  lock_if bus();

  lock_ctrl #(
    .DEFAULT_CODE (16'h1234),
    .MAX_TRIES    (32'd3),
    .OPEN_CYCLES  (32'd20),
    .ERR_CYCLES   (32'd8),
    .LOCK_CYCLES  (32'd40),
    .IDLE_TIMEOUT (32'd30),
    .BLINK_CYCLES (32'd4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int    n_tests = 0;
  int    n_fail  = 0;
  bit    chk_en  = 1'b0;

  // Model: mode name, digits typed so far, stored code, fails, cycles since (re)start.
  string m_mode = "idle";
  int    m_digits[$];
  int    m_code[4];
  int    m_fails = 0;
  int    m_age   = 0;

  function automatic int limit_of(string m);
    if (m == "entry" || m == "newcode") return 30;
    if (m == "open")    return 20;
    if (m == "error")   return 8;
    if (m == "lockout") return 40;
    return 0;
  endfunction

  function automatic bit code_ok();
    if (m_digits.size() != 4) return 1'b0;
    for (int i = 0; i < 4; i++) if (m_digits[i] != m_code[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic go_idle();
    m_mode = "idle";
    m_digits.delete();
    m_age = 0;
  endtask

  task automatic model_step();
    int k;
    if (rst) begin
      go_idle();
      m_code  = '{1, 2, 3, 4};
      m_fails = 0;
      return;
    end
    m_age++;
    if (limit_of(m_mode) > 0 && m_age >= limit_of(m_mode)) begin
      if (m_mode == "lockout") m_fails = 0;
      go_idle();
      return;
    end
    if (!bus.key_valid) return;
    k = int'(bus.key_code);
    if (m_mode == "idle") begin
      if (k <= 9) begin
        m_mode = "entry";
        m_digits.delete();
        m_digits.push_back(k);
        m_age = 0;
      end
    end else if (m_mode == "entry" || m_mode == "newcode") begin
      m_age = 0;
      if (k <= 9) begin
        if (m_digits.size() < 4) m_digits.push_back(k);
      end else if (k == 11) begin
        if (m_mode == "entry") go_idle();
        else m_mode = "open";
      end else if (k == 10) begin
        if (m_mode == "newcode") begin
          if (m_digits.size() == 4) begin
            for (int i = 0; i < 4; i++) m_code[i] = m_digits[i];
            m_mode = "open";
          end
        end else if (code_ok()) begin
          m_mode  = "open";
          m_fails = 0;
        end else begin
          if (m_fails < 3) m_fails = m_fails + 1;
          if (m_fails == 3) m_mode = "lockout";
          else m_mode = "error";
        end
      end
    end else if (m_mode == "open") begin
      if (k == 11) go_idle();
      else if (k == 12) begin
        m_mode = "newcode";
        m_digits.delete();
        m_age = 0;
      end
    end
  endtask

  function automatic logic [15:0] exp_disp();
    logic [15:0] w;
    if (m_mode == "open") return 16'hAAAA;
    if (m_mode == "error" || m_mode == "lockout") return 16'hEEEE;
    w = 16'hFFFF;
    if (m_mode == "entry" || m_mode == "newcode")
      foreach (m_digits[i]) w = {w[11:0], 4'(m_digits[i])};
    return w;
  endfunction

  function automatic logic exp_en();
    if (m_mode == "idle") return 1'b0;
    if (m_mode == "lockout") return ((m_age / 4) % 2) == 0;
    return 1'b1;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    logic [15:0] ed;
    logic        ee, eu, ea;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        ed = exp_disp();
        ee = exp_en();
        eu = (m_mode == "open" || m_mode == "newcode");
        ea = (m_mode == "lockout");
        n_tests++;
        if (bus.disp_data !== ed || bus.disp_en !== ee || bus.unlock !== eu || bus.alarm !== ea) begin
          n_fail++;
          $display("FAIL model t=%0t got disp=%h en=%b unlock=%b alarm=%b, want disp=%h en=%b unlock=%b alarm=%b (%s)",
                   $time, bus.disp_data, bus.disp_en, bus.unlock, bus.alarm, ed, ee, eu, ea, m_mode);
        end
      end
    end
  end

  task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(string name, logic act, logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  task automatic cyc(logic v, logic [3:0] c);
    @(negedge clk);
    bus.key_valid = v;
    bus.key_code  = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic press(logic [3:0] c);
    cyc(1'b1, c);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.key_valid = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic chk_reset_outputs(string tag);
    chk16({tag, "_disp"}, bus.disp_data, 16'hFFFF);
    chk1({tag, "_en"}, bus.disp_en, 1'b0);
    chk1({tag, "_unlock"}, bus.unlock, 1'b0);
    chk1({tag, "_alarm"}, bus.alarm, 1'b0);
  endtask

  task automatic enter4(logic [3:0] a, logic [3:0] b, logic [3:0] c, logic [3:0] d);
    press(a); press(b); press(c); press(d); press(4'hA);
  endtask

  initial begin
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    // 1: correct code opens for exactly 20 cycles
    do_reset();
    chk_reset_outputs("reset");
    press(4'h1); chk16("t1_d1", bus.disp_data, 16'hFFF1);
    press(4'h2); chk16("t1_d2", bus.disp_data, 16'hFF12);
    press(4'h3); chk16("t1_d3", bus.disp_data, 16'hF123);
    press(4'h4); chk16("t1_d4", bus.disp_data, 16'h1234);
    press(4'hA); chk1("t1_unlock", bus.unlock, 1'b1); chk16("t1_open", bus.disp_data, 16'hAAAA);
    idle(19);    chk1("t1_still_open", bus.unlock, 1'b1);
    idle(1);     chk1("t1_relock", bus.unlock, 1'b0); chk1("t1_blank", bus.disp_en, 1'b0);
    // 2: wrong code, three in a row lock out
    enter4(4'h1, 4'h2, 4'h3, 4'h5); chk16("t2_err", bus.disp_data, 16'hEEEE); chk1("t2_no_unlock", bus.unlock, 1'b0);
    idle(7);     chk16("t2_err_hold", bus.disp_data, 16'hEEEE);
    idle(1);     chk1("t2_err_done", bus.disp_en, 1'b0);
    enter4(4'h1, 4'h2, 4'h3, 4'h5); idle(8);
    enter4(4'h1, 4'h2, 4'h3, 4'h5); chk1("t2_alarm", bus.alarm, 1'b1); chk1("t2_blink_on", bus.disp_en, 1'b1);
    idle(3);     chk1("t2_blink_on3", bus.disp_en, 1'b1);
    idle(1);     chk1("t2_blink_off", bus.disp_en, 1'b0);
    press(4'h1); chk16("t2_key_ignored", bus.disp_data, 16'hEEEE);
    idle(34);    chk1("t2_alarm_hold", bus.alarm, 1'b1);
    idle(1);     chk1("t2_alarm_off", bus.alarm, 1'b0); chk1("t2_idle_en", bus.disp_en, 1'b0);
    enter4(4'h1, 4'h2, 4'h3, 4'h5); chk1("t2_fail_reset", bus.alarm, 1'b0); chk16("t2_err_again", bus.disp_data, 16'hEEEE);
    idle(8);
    // 3: short code fails; fifth digit ignored
    press(4'h1); press(4'h2); press(4'hA); chk16("t3_short", bus.disp_data, 16'hEEEE); chk1("t3_no_lock", bus.alarm, 1'b0);
    idle(8);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'h5);
    chk16("t3_buf_full", bus.disp_data, 16'h1234);
    press(4'hE); chk16("t3_ignored_key", bus.disp_data, 16'h1234);
    press(4'hA); chk1("t3_open", bus.unlock, 1'b1);
    // 4: change code while open
    press(4'hC); chk16("t4_new_blank", bus.disp_data, 16'hFFFF); chk1("t4_new_unlock", bus.unlock, 1'b1);
    press(4'h9); press(4'h8); press(4'h7); press(4'h6); chk16("t4_new_buf", bus.disp_data, 16'h9876);
    press(4'hA); chk16("t4_open", bus.disp_data, 16'hAAAA);
    idle(19);    chk1("t4_restart", bus.unlock, 1'b1);
    idle(1);     chk1("t4_expire", bus.unlock, 1'b0);
    enter4(4'h1, 4'h2, 4'h3, 4'h4); chk16("t4_old_code", bus.disp_data, 16'hEEEE);
    idle(8);
    enter4(4'h9, 4'h8, 4'h7, 4'h6); chk16("t4_new_code", bus.disp_data, 16'hAAAA);
    press(4'hC); press(4'h1); chk16("t4_partial", bus.disp_data, 16'hFFF1);
    press(4'hA); chk16("t4_short_enter", bus.disp_data, 16'hFFF1);
    press(4'hB); chk16("t4_cancel", bus.disp_data, 16'hAAAA); chk1("t4_cancel_unlock", bus.unlock, 1'b1);
    press(4'hB); chk1("t4_clear_relock", bus.unlock, 1'b0); chk1("t4_clear_en", bus.disp_en, 1'b0);
    // 5: idle timeout, key on the expiry edge dropped
    press(4'h1); idle(29); chk16("t5_before", bus.disp_data, 16'hFFF1);
    press(4'h2); chk1("t5_timeout", bus.disp_en, 1'b0); chk16("t5_timeout_disp", bus.disp_data, 16'hFFFF);
    idle(1);     chk1("t5_dropped", bus.disp_en, 1'b0);
    press(4'h1); idle(20); press(4'h2); idle(29); chk16("t5_restarted", bus.disp_data, 16'hFF12);
    idle(1);     chk1("t5_timeout2", bus.disp_en, 1'b0);
    // 6: reset mid-OPEN and mid-LOCKOUT
    enter4(4'h9, 4'h8, 4'h7, 4'h6); chk1("t6_open", bus.unlock, 1'b1);
    idle(3); do_reset(); chk_reset_outputs("t6_rst_open");
    enter4(4'h1, 4'h2, 4'h3, 4'h4); chk1("t6_default_code", bus.unlock, 1'b1);
    press(4'hB);
    enter4(4'h5, 4'h5, 4'h5, 4'h5); idle(8);
    enter4(4'h5, 4'h5, 4'h5, 4'h5); idle(8);
    enter4(4'h5, 4'h5, 4'h5, 4'h5); chk1("t6_lockout", bus.alarm, 1'b1);
    idle(5); do_reset(); chk_reset_outputs("t6_rst_lock");
    enter4(4'h1, 4'h2, 4'h3, 4'h4); chk1("t6_open_after", bus.unlock, 1'b1);
    idle(3);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
